fft64_result_packer: RTL and testbench

//   Write-side counterpart to the fft64 sample reader path. Collects the fft64 complex output

---
 rtl/fft64_result_packer.sv | 135 +++++++++++++
 tb/tb_fft64_result_packer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft64_result_packer.sv
// fft64_result_packer: packs the fft64 complex output stream into 128-bit words
// (four sign-extended {im, re} lanes per word, 16 words per 64-point frame) and
// buffers up to two finished words in front of the result writer.
module fft64_result_packer #(
    parameter int DW     = 11,
    parameter int LANE_W = 32,
    parameter int LANES  = 4,
    parameter int FRAME  = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    valid_i,
    input  logic signed [DW-1:0]    xr,
    input  logic signed [DW-1:0]    xi,
    output logic                    full,
    output logic [LANE_W*LANES-1:0] writer_data,
    output logic                    writer_en,
    input  logic                    writer_full,
    output logic                    frame_done,
    output logic                    overflow,
    output logic [1:0]              state
);

    localparam int WORD_W  = LANE_W * LANES;
    localparam int HALF_W  = LANE_W / 2;
    localparam int WPF     = FRAME / LANES;
    localparam int LANE_AW = $clog2(LANES);
    localparam int SAMP_AW = $clog2(FRAME);
    localparam int WORD_AW = $clog2(WPF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_q;
    logic [WORD_W-1:0]    asm_q, asm_d;
    logic [LANE_AW-1:0]   lane_q, lane_d;
    logic [SAMP_AW-1:0]   sample_cnt_q;
    logic [WORD_AW-1:0]   word_cnt_q;
    logic [WORD_W-1:0]    mem_q [2];
    logic                 wr_ptr_q, rd_ptr_q;
    logic [1:0]           count_q, count_d;
    logic                 overflow_q;

    logic                 accept, push, pop;
    logic [LANE_W-1:0]    sample_word;
    logic [WORD_W-1:0]    word_in;

    assign sample_word = {{(HALF_W-DW){xi[DW-1]}}, xi, {(HALF_W-DW){xr[DW-1]}}, xr};

    // full depends only on registered occupancy, so a push can never overrun the queue
    assign full        = (count_q == 2'd2);
    assign accept      = valid_i & ~full;
    assign push        = accept & (lane_q == LANE_AW'(LANES-1));
    assign writer_en   = (count_q != 2'd0) & ~writer_full;
    assign pop         = writer_en;
    assign writer_data = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    assign frame_done  = writer_en & (word_cnt_q == WORD_AW'(WPF-1));
    assign overflow    = overflow_q;
    assign state       = state_q;

    // Next-state for the lane assembler and the queue occupancy
    always_comb begin
        word_in = asm_q;
        word_in[LANE_W*lane_q +: LANE_W] = sample_word;
        asm_d   = asm_q;
        lane_d  = lane_q;
        if (accept) begin
            if (push) begin
                asm_d  = '0;
                lane_d = '0;
            end else begin
                asm_d  = word_in;
                lane_d = lane_q + 1'b1;
            end
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Datapath registers: assembler, counters, word queue, sticky overflow
    always_ff @(posedge CLK) begin
        if (RST) begin
            asm_q        <= '0;
            lane_q       <= '0;
            sample_cnt_q <= '0;
            word_cnt_q   <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            asm_q   <= asm_d;
            lane_q  <= lane_d;
            count_q <= count_d;
            if (accept)
                sample_cnt_q <= sample_cnt_q + 1'b1;
            if (push) begin
                mem_q[wr_ptr_q] <= word_in;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q   <= ~rd_ptr_q;
                word_cnt_q <= word_cnt_q + 1'b1;
            end
            if (valid_i & full)
                overflow_q <= 1'b1;
        end
    end

    // Frame-level debug FSM; DRAIN re-enters FILL directly so frames can run back to back
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:  if (accept) state_q <= FILL;
                FILL:  if (accept && sample_cnt_q == SAMP_AW'(FRAME-1)) state_q <= DRAIN;
                DRAIN: begin
                    if (accept)
                        state_q <= FILL;
                    else if (count_q == 2'd0)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft64_result_packer.sv
// Scoreboard bench for fft64_result_packer: stimulus pushes expected words,
// a negedge monitor pops and compares whenever writer_en is seen.
module tb_fft64_result_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_i;
    logic [10:0]  xr, xi;
    logic         full;
    logic [127:0] writer_data;
    logic         writer_en;
    logic         writer_full;
    logic         frame_done;
    logic         overflow;
    logic [1:0]   state;

    fft64_result_packer #(.DW(11), .LANE_W(32), .LANES(4), .FRAME(64)) dut (
        .CLK(clk), .RST(rst), .valid_i(valid_i), .xr(xr), .xi(xi),
        .full(full), .writer_data(writer_data), .writer_en(writer_en),
        .writer_full(writer_full), .frame_done(frame_done),
        .overflow(overflow), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } exp_t;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           en_cnt  = 0;
    int           fd_cnt  = 0;

    // reference packing model
    logic [127:0] m_asm;
    int           m_lane, m_idx, m_samples;
    bit           hand_mode;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_asm = '0; m_lane = 0; m_idx = 0; m_samples = 0;
    endtask

    task automatic model_accept(input logic [10:0] r, input logic [10:0] i);
        m_asm[32*m_lane +: 32] = {{5{i[10]}}, i, {5{r[10]}}, r};
        m_lane++;
        m_samples = (m_samples + 1) % 64;
        if (m_lane == 4) begin
            if (!hand_mode) sb.push_back('{data: m_asm, last: (m_idx == 15)});
            m_idx  = (m_idx + 1) % 16;
            m_asm  = '0;
            m_lane = 0;
        end
    endtask

    // hand-computed word, queued before its samples are sent
    task automatic expect_word(input logic [127:0] w);
        sb.push_back('{data: w, last: (m_idx == 15)});
    endtask

    task automatic send(input logic [10:0] r, input logic [10:0] i);
        valid_i = 1'b1; xr = r; xi = i;
        @(posedge clk); #1;
        valid_i = 1'b0;
        model_accept(r, i);
    endtask

    task automatic drop(input logic [10:0] r, input logic [10:0] i);
        valid_i = 1'b1; xr = r; xi = i;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        for (k = 0; k < 50; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        if (sb.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: got %0d words pending expected 0", name, sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: every writer_en must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (writer_en) begin
                en_cnt++;
                if (frame_done) fd_cnt++;
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_word: got %h expected none", writer_data);
                end else begin
                    e = sb.pop_front();
                    check("word_data", writer_data, e.data);
                    check("frame_done_on_word", 128'(frame_done), 128'(e.last));
                end
            end else if (frame_done) begin
                n_tests++; n_fail++;
                $display("FAIL frame_done_without_en: got 1 expected 0");
            end
        end
    end

    initial begin
        int en0, fd0;
        bit saw_idle;
        rst = 1'b1; valid_i = 1'b0; xr = '0; xi = '0; writer_full = 1'b0;
        hand_mode = 1'b0;
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_full", 128'(full), 128'd0);
        check("rst_writer_en", 128'(writer_en), 128'd0);
        check("rst_writer_data", writer_data, 128'd0);
        check("rst_frame_done", 128'(frame_done), 128'd0);
        check("rst_overflow", 128'(overflow), 128'd0);
        check("rst_state", 128'(state), 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1. impulse frame
        hand_mode = 1'b1;
        fd0 = fd_cnt;
        for (int k = 0; k < 64; k++) begin
            if (k % 4 == 0)
                expect_word(k == 0 ? 128'h0000_0000_0000_0000_0000_0000_0001_0000 : 128'h0);
            send(11'h000, (k == 0) ? 11'h001 : 11'h000);
            if (k == 0) check("impulse_state_fill", 128'(state), 128'd1);
        end
        check("impulse_state_drain", 128'(state), 128'd2);
        drain("impulse");
        check("impulse_frame_done_cnt", 128'(fd_cnt - fd0), 128'd1);
        check("impulse_state_idle", 128'(state), 128'd0);

        // 2. sign extension
        expect_word(128'h0000_0000_0000_0000_FFFF_FFFF_03FF_FC00);
        send(11'h400, 11'h3FF);
        send(11'h7FF, 11'h7FF);
        send(11'h000, 11'h000);
        send(11'h000, 11'h000);
        hand_mode = 1'b0;
        drain("signext");

        // 3. backpressure: two words fill the queue
        writer_full = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send(11'(k + 1), 11'(-(k + 1)));
            check("bp_no_writer_en", 128'(writer_en), 128'd0);
            if (k == 6) check("bp_full_after_7", 128'(full), 128'd0);
        end
        check("bp_full_after_8", 128'(full), 128'd1);
        writer_full = 1'b0;
        #1;
        check("bp_release_en", 128'(writer_en), 128'd1);
        check("bp_full_until_pop", 128'(full), 128'd1);
        @(posedge clk); #1;
        check("bp_full_after_pop", 128'(full), 128'd0);
        drain("bp");
        for (int k = 0; k < 4; k++) send(11'(100 + k), 11'(k));
        drain("bp_tail");
        check("bp_overflow", 128'(overflow), 128'd0);

        // 4. overflow: drop a sample while full
        writer_full = 1'b1;
        for (int k = 0; k < 8; k++) send(11'(20 + k), 11'h7F0);
        check("ovf_full", 128'(full), 128'd1);
        drop(11'd5, 11'd0);
        check("ovf_set", 128'(overflow), 128'd1);
        writer_full = 1'b0;
        drain("ovf");
        check("ovf_sticky", 128'(overflow), 128'd1);
        fd0 = fd_cnt;
        while (m_samples != 0) send(11'h000, 11'h000);
        check("ovf_frame_end_drain", 128'(state), 128'd2);
        drain("ovf_frame");
        check("ovf_frame_done_cnt", 128'(fd_cnt - fd0), 128'd1);

        // 5. back-to-back frames
        en0 = en_cnt; fd0 = fd_cnt; saw_idle = 1'b0;
        for (int k = 0; k < 128; k++) begin
            send(11'(k), ~11'(k));
            if (state == 2'd0) saw_idle = 1'b1;
        end
        drain("b2b");
        check("b2b_no_idle", 128'(saw_idle), 128'd0);
        check("b2b_writer_en_cnt", 128'(en_cnt - en0), 128'd32);
        check("b2b_frame_done_cnt", 128'(fd_cnt - fd0), 128'd2);

        // 6. reset mid-frame
        for (int k = 0; k < 10; k++) send(11'd9, 11'd3);
        check("midrst_sb_empty", 128'(sb.size()), 128'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("midrst_overflow", 128'(overflow), 128'd0);
        check("midrst_state", 128'(state), 128'd0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_partial", 128'(writer_en), 128'd0);
        en0 = en_cnt; fd0 = fd_cnt;
        hand_mode = 1'b1;
        expect_word(128'h0000_0004_0000_0003_0000_0002_0000_0001);
        for (int k = 1; k <= 4; k++) send(11'(k), 11'd0);
        hand_mode = 1'b0;
        while (m_samples != 0) send(11'h000, 11'h001);
        drain("midrst");
        check("midrst_words", 128'(en_cnt - en0), 128'd16);
        check("midrst_frame_done", 128'(fd_cnt - fd0), 128'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
